nubus_master_req: RTL and testbench

NUBUS_MASTER_REQ -- requirements
Module: nubus_master_req

---
 rtl/nubus_master_req.sv | 172 +++++++++++++++++
 tb/tb_nubus_master_req.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nubus_master_req.sv
// NuBus master request/ownership sequencer paired with nubus_arbiter.
// Optional request timeout enabled by defining NUBUS_ARB_TIMEOUT_EN.
module nubus_master_req #(
  parameter int unsigned ARB_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       nub_clk,
  input  logic       nub_reset,
  input  logic [3:0] idn,
  input  logic       startn,
  input  logic       ackn,
  input  logic       grant,
  input  logic       mst_req,
  input  logic       mst_lock,
  input  logic       mst_done,
  output logic       rqstn_o,
  output logic       arbcyn,
  output logic       mst_start,
  output logic       mst_own,
  output logic       arb_timeout
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ARB,
    WON,
    OWN
  } state_t;

  localparam logic [3:0] ARB_LOAD = 4'(ARB_CYCLES);

  if (ARB_CYCLES < 2 || ARB_CYCLES > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("nubus_master_req: illegal ARB_CYCLES or TIMEOUT_CYCLES");
  end

  state_t     state_q;
  logic       busy_q;
  logic       busy_d;
  logic [3:0] cnt_q;
  logic       bus_free;
  logic       arb_go;
  logic       contending;
  logic       tmo_hit;

  // Attention cycles (start and ack together) leave the bus idle.
  always_comb begin
    busy_d = busy_q;
    if (!ackn) begin
      busy_d = 1'b0;
    end else if (!startn) begin
      busy_d = 1'b1;
    end
    bus_free = !ackn || !busy_d;
    arb_go   = !busy_d || !startn;
  end

  assign contending = (state_q == REQ) || (state_q == ARB) ||
                      (state_q == WON);

`ifdef NUBUS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_q;

  assign tmo_hit = contending && mst_req && (tmo_q >= TMO_MAX);

  always_ff @(posedge nub_clk or posedge nub_reset) begin
    if (nub_reset) begin
      tmo_q       <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= tmo_hit;
      if (contending && mst_req && !tmo_hit) begin
        tmo_q <= tmo_q + 1'b1;
      end else if (state_q == IDLE && mst_req) begin
        tmo_q <= TW'(1);
      end else begin
        tmo_q <= '0;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge nub_clk or posedge nub_reset) begin
    if (nub_reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      rqstn_o   <= 1'b1;
      arbcyn    <= 1'b1;
      mst_start <= 1'b0;
      mst_own   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      mst_start <= 1'b0;
      if (contending && (!mst_req || tmo_hit)) begin
        state_q <= IDLE;
        rqstn_o <= 1'b1;
        arbcyn  <= 1'b1;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (mst_req) begin
              state_q <= REQ;
              rqstn_o <= 1'b0;
            end
          end
          REQ: begin
            if (arb_go) begin
              state_q <= ARB;
              arbcyn  <= 1'b0;
              cnt_q   <= ARB_LOAD;
            end
          end
          ARB: begin
            if (cnt_q > 4'd1) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              cnt_q <= '0;
              if (!grant) begin
                state_q <= REQ;
                arbcyn  <= 1'b1;
              end else if (bus_free) begin
                state_q   <= OWN;
                rqstn_o   <= 1'b1;
                arbcyn    <= 1'b1;
                mst_start <= 1'b1;
                mst_own   <= 1'b1;
              end else begin
                state_q <= WON;
              end
            end
          end
          WON: begin
            if (bus_free) begin
              state_q   <= OWN;
              rqstn_o   <= 1'b1;
              arbcyn    <= 1'b1;
              mst_start <= 1'b1;
              mst_own   <= 1'b1;
            end
          end
          OWN: begin
            if (mst_done) begin
              if (mst_req && mst_lock) begin
                mst_start <= 1'b1;
              end else begin
                state_q <= IDLE;
                mst_own <= 1'b0;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // The card ID must be stable whenever this card is contending or owning.
  always_ff @(posedge nub_clk) begin
    if (!nub_reset && state_q != IDLE) begin
      assert (!$isunknown(idn));
    end
  end

endmodule

// File: tb/tb_nubus_master_req.sv
// Scoreboard bench for nubus_master_req: single card scenarios plus
// a two-card contest with a behavioural arbiter and bus responder.
module tb_nubus_master_req;

  localparam logic [3:0] ID_A   = 4'h9;
  localparam logic [3:0] ID_B   = 4'h3;
  localparam logic [3:0] IDN_A  = ~ID_A;
  localparam logic [3:0] IDN_B  = ~ID_B;
  localparam bit         A_WINS = (ID_A > ID_B);

  // stimulus: {req, lock, done, startn, ackn, lose}
  // expect:   {rqstn, arbcyn, start, own, timeout}
  localparam logic [5:0] BASIC_ST [7] = '{
    6'b100110, 6'b100110, 6'b100110, 6'b100110,
    6'b100110, 6'b001110, 6'b000110};
  localparam logic [4:0] BASIC_EX [7] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b11110,
    5'b11010, 5'b11000, 5'b11000};

  localparam logic [5:0] BUSY_ST [7] = '{
    6'b100110, 6'b100010, 6'b100110, 6'b100110,
    6'b101110, 6'b100100, 6'b001110};
  localparam logic [4:0] BUSY_EX [7] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b00000,
    5'b00000, 5'b11110, 5'b11000};

  localparam logic [5:0] LOSE_ST [8] = '{
    6'b100110, 6'b100111, 6'b100111, 6'b100111,
    6'b100110, 6'b100110, 6'b100110, 6'b001110};
  localparam logic [4:0] LOSE_EX [8] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b01000,
    5'b00000, 5'b00000, 5'b11110, 5'b11000};

  localparam logic [5:0] ABORT_ST [4] = '{
    6'b100110, 6'b100110, 6'b000110, 6'b000110};
  localparam logic [4:0] ABORT_EX [4] = '{
    5'b01000, 5'b00000, 5'b11000, 5'b11000};

  localparam logic [5:0] LOCK_ST [9] = '{
    6'b110110, 6'b110110, 6'b110110, 6'b110110, 6'b110110,
    6'b111110, 6'b110110, 6'b001110, 6'b000110};
  localparam logic [4:0] LOCK_EX [9] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b11110, 5'b11010,
    5'b11110, 5'b11010, 5'b11000, 5'b11000};

  localparam logic [6:0] RST_ST [7] = '{
    7'b0100110, 7'b0100110, 7'b1100110, 7'b1100110,
    7'b0100110, 7'b0100110, 7'b0000110};
  localparam logic [4:0] RST_EX [7] = '{
    5'b01000, 5'b00000, 5'b11000, 5'b11000,
    5'b01000, 5'b00000, 5'b11000};

  localparam logic [5:0] TMO_ST [10] = '{
    6'b100110, 6'b100111, 6'b100111, 6'b100111, 6'b100111,
    6'b100111, 6'b100111, 6'b100111, 6'b100111, 6'b000110};
`ifdef NUBUS_ARB_TIMEOUT_EN
  localparam logic [4:0] TMO_EX [10] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b00000,
    5'b00000, 5'b01000, 5'b00000, 5'b11001, 5'b11000};
`else
  localparam logic [4:0] TMO_EX [10] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b01000, 5'b00000,
    5'b00000, 5'b01000, 5'b00000, 5'b00000, 5'b11000};
`endif

  logic clk = 1'b0;
  logic rst;
  logic startn, ackn;
  logic req_a, lock_a, done_a, lose_a;
  logic req_b, lock_b, done_b;
  logic grant_a, grant_b;
  logic rqstn_a, arbcyn_a, start_a, own_a, tmo_a;
  logic rqstn_b, arbcyn_b, start_b, own_b, tmo_b;
  logic [4:0] outs_a;
  logic [4:0] exp_q [$];
  int vec = 0;
  int miss = 0;

  always #5 clk = ~clk;

  assign outs_a = {rqstn_a, arbcyn_a, start_a, own_a, tmo_a};

  // Behavioural arbiter: highest contending ID wins.
  assign grant_a = !arbcyn_a && !lose_a && (arbcyn_b || (ID_A > ID_B));
  assign grant_b = !arbcyn_b && (arbcyn_a || (ID_B > ID_A));

  nubus_master_req #(.ARB_CYCLES(2), .TIMEOUT_CYCLES(8)) u_a (
    .nub_clk(clk), .nub_reset(rst), .idn(IDN_A),
    .startn(startn), .ackn(ackn), .grant(grant_a),
    .mst_req(req_a), .mst_lock(lock_a), .mst_done(done_a),
    .rqstn_o(rqstn_a), .arbcyn(arbcyn_a), .mst_start(start_a),
    .mst_own(own_a), .arb_timeout(tmo_a));

  nubus_master_req #(.ARB_CYCLES(2), .TIMEOUT_CYCLES(8)) u_b (
    .nub_clk(clk), .nub_reset(rst), .idn(IDN_B),
    .startn(startn), .ackn(ackn), .grant(grant_b),
    .mst_req(req_b), .mst_lock(lock_b), .mst_done(done_b),
    .rqstn_o(rqstn_b), .arbcyn(arbcyn_b), .mst_start(start_b),
    .mst_own(own_b), .arb_timeout(tmo_b));

  task automatic drive(input logic [5:0] s);
    {req_a, lock_a, done_a, startn, ackn, lose_a} = s;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    exp_q.push_back(5'b11000);
    @(negedge clk);
    e = exp_q.pop_front();
    vec++;
    if (outs_a !== e) begin
      miss++;
      $display("FAIL reset_hold: got %b want %b", outs_a, e);
    end
    rst = 1'b0;
    exp_q.push_back(5'b11000);
    @(negedge clk);
    e = exp_q.pop_front();
    vec++;
    if (outs_a !== e) begin
      miss++;
      $display("FAIL reset_release: got %b want %b", outs_a, e);
    end
  endtask

  task automatic test_basic();
    logic [4:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(BASIC_ST[i]);
      exp_q.push_back(BASIC_EX[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL basic step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_busy_won();
    logic [4:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(BUSY_ST[i]);
      exp_q.push_back(BUSY_EX[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL busy_won step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_lose();
    logic [4:0] e;
    for (int i = 0; i < 8; i++) begin
      drive(LOSE_ST[i]);
      exp_q.push_back(LOSE_EX[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL lose step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [4:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(ABORT_ST[i]);
      exp_q.push_back(ABORT_EX[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL abort step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_lock();
    logic [4:0] e;
    for (int i = 0; i < 9; i++) begin
      drive(LOCK_ST[i]);
      exp_q.push_back(LOCK_EX[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL lock step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_reset_mid_arb();
    logic [4:0] e;
    logic [6:0] s;
    for (int i = 0; i < 7; i++) begin
      s = RST_ST[i];
      rst = s[6];
      drive(s[5:0]);
      exp_q.push_back(RST_EX[i]);
      if (i == 2) #1;
      else @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL reset_mid_arb step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [4:0] e;
    for (int i = 0; i < 10; i++) begin
      drive(TMO_ST[i]);
      exp_q.push_back(TMO_EX[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      vec++;
      if (outs_a !== e) begin
        miss++;
        $display("FAIL timeout step %0d: got %b want %b", i, outs_a, e);
      end
    end
  endtask

  task automatic test_two_masters();
    int ph;
    int owner;
    bit seen;
    bit b_owned;
    ph = 0;
    owner = 0;
    seen = 1'b0;
    b_owned = 1'b0;
    drive(6'b100110);
    req_b = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      vec++;
      if (own_a && own_b) begin
        miss++;
        $display("FAIL dual_own cyc %0d: got own_a=%b own_b=%b want at most one",
                 c, own_a, own_b);
      end
      if (!seen && (own_a || own_b)) begin
        seen = 1'b1;
        vec++;
        if (own_a !== A_WINS) begin
          miss++;
          $display("FAIL first_owner: got own_a=%b want %b", own_a, A_WINS);
        end
      end
      if (own_a) begin
        vec++;
        if (rqstn_b !== 1'b0) begin
          miss++;
          $display("FAIL loser_rqst cyc %0d: got %b want 0", c, rqstn_b);
        end
      end
      if (own_b) b_owned = 1'b1;
      startn = 1'b1;
      ackn   = 1'b1;
      done_a = 1'b0;
      done_b = 1'b0;
      if (start_a || start_b) begin
        startn = 1'b0;
        ph     = 1;
        owner  = start_a ? 1 : 2;
      end else if (ph == 1) begin
        ph = 2;
      end else if (ph == 2) begin
        ackn = 1'b0;
        ph   = 0;
        if (owner == 1) begin
          done_a = 1'b1;
          req_a  = 1'b0;
        end else begin
          done_b = 1'b1;
          req_b  = 1'b0;
        end
      end
    end
    vec++;
    if (b_owned !== 1'b1) begin
      miss++;
      $display("FAIL loser_won: got %b want 1", b_owned);
    end
    vec++;
    if ({rqstn_a, rqstn_b, own_a, own_b} !== 4'b1100) begin
      miss++;
      $display("FAIL both_idle: got %b want 1100",
               {rqstn_a, rqstn_b, own_a, own_b});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(6'b000110);
    req_b  = 1'b0;
    lock_b = 1'b0;
    done_b = 1'b0;
    test_reset();
    test_basic();
    test_busy_won();
    test_lose();
    test_abort();
    test_lock();
    test_reset_mid_arb();
    test_timeout();
    test_two_masters();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
